// File: rtl/inv_key_schedule.sv
// AES-128 inverse key schedule.
// Loads the round-10 key and steps backwards one round per accepted transfer.
// Round keys come out as 10, 9, ..., 0 on a valid/ready stream, so the
// decryption datapath does not have to store all eleven round keys.
module inv_key_schedule (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         key_ready,
  output logic         key_valid,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         busy,
  output logic         done
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Forward AES S-box; the inverse schedule recomputes SubWord on the way back
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Round constant byte used when stepping back from round i to round i-1
  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // SubWord(RotWord(w)): rotate left one byte, then S-box each byte
  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    logic [31:0] r;
    r = {w[23:0], w[31:24]};
    return {SBOX[r[31:24]], SBOX[r[23:16]], SBOX[r[15:8]], SBOX[r[7:0]]};
  endfunction

  // Recover round key i-1 from round key i. w3 of the older key is needed
  // before w0 can be undone, so p3 is formed first and fed to SubWord.
  function automatic logic [127:0] inv_step(input logic [127:0] k, input logic [3:0] i);
    logic [31:0] w0, w1, w2, w3, p0, p1, p2, p3;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    p3 = w3 ^ w2;
    p2 = w2 ^ w1;
    p1 = w1 ^ w0;
    p0 = w0 ^ sub_rot(p3) ^ {rcon(i), 24'h000000};
    return {p0, p1, p2, p3};
  endfunction

  state_t       state_q, state_d;
  logic         key_valid_q, key_valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [127:0] round_key_q, round_key_d;
  logic [3:0]   round_idx_q, round_idx_d;
  logic         xfer;

  assign xfer = key_valid_q & key_ready;

  // Next-state logic: load on start when idle, step back on each transfer
  always_comb begin
    state_d     = state_q;
    key_valid_d = key_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    round_key_d = round_key_q;
    round_idx_d = round_idx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = EMIT;
          round_key_d = key_in;
          round_idx_d = 4'd10;
          key_valid_d = 1'b1;
          busy_d      = 1'b1;
        end
      end
      EMIT: begin
        if (xfer) begin
          if (round_idx_q != 4'd0) begin
            round_key_d = inv_step(round_key_q, round_idx_q);
            round_idx_d = round_idx_q - 4'd1;
          end else begin
            state_d     = IDLE;
            key_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset clears everything at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      key_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      round_key_q <= '0;
      round_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      key_valid_q <= key_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      round_key_q <= round_key_d;
      round_idx_q <= round_idx_d;
    end
  end

  assign key_valid = key_valid_q;
  assign round_key = round_key_q;
  assign round_idx = round_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_inv_key_schedule.sv
// Bench for inv_key_schedule: a forward key-expansion model fills a queue
// with the expected 10..0 round keys; a monitor pops one per transfer.
module tb_inv_key_schedule;

  localparam logic [127:0] K10_FIPS = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K1_FIPS  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K0_FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K10_TEAM = 128'h3ea222a7987a5f4a38dc254fec19fc49;
  localparam logic [127:0] K1_TEAM  = 128'he12186f2c110b4cae152fd9ec119b8c7;
  localparam logic [127:0] K0_TEAM  = 128'h534f4d452031323820424954204b4559;

  logic         clk = 1'b0;
  logic         reset, start, key_ready;
  logic [127:0] key_in;
  logic         key_valid, busy, done;
  logic [127:0] round_key;
  logic [3:0]   round_idx;

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] key;
  } exp_t;

  exp_t         sb_q[$];
  logic [127:0] rk [0:10];
  int           total = 0;
  int           bad = 0;
  int           xfers = 0;

  always #5 clk = ~clk;

  inv_key_schedule dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .key_in    (key_in),
    .key_ready (key_ready),
    .key_valid (key_valid),
    .round_key (round_key),
    .round_idx (round_idx),
    .busy      (busy),
    .done      (done)
  );

  // GF(2^8) multiply, AES polynomial
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  // S-box from first principles: multiplicative inverse then affine map
  function automatic logic [7:0] sbox_m(input logic [7:0] b);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, b);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  // Forward AES-128 key expansion from the round-0 key into rk[0..10]
  task automatic expand(input logic [127:0] k0);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    w[0] = k0[127:96]; w[1] = k0[95:64]; w[2] = k0[63:32]; w[3] = k0[31:0];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m(t[31:24]), sbox_m(t[23:16]), sbox_m(t[15:8]), sbox_m(t[7:0])};
        t = t ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic push_all();
    exp_t e;
    for (int r = 10; r >= 0; r--) begin
      e.idx = r[3:0];
      e.key = rk[r];
      sb_q.push_back(e);
    end
  endtask

  // Scoreboard: every transfer must match the next expected key
  always @(negedge clk) begin
    exp_t e;
    if (!reset && key_valid && key_ready) begin
      xfers++;
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected got idx=%0d key=%h required none", round_idx, round_key);
      end else begin
        e = sb_q.pop_front();
        if ({round_idx, round_key} !== {e.idx, e.key}) begin
          bad++;
          $display("FAIL sb_key got idx=%0d key=%h required idx=%0d key=%h",
                   round_idx, round_key, e.idx, e.key);
        end
      end
    end
  end

  task automatic start_seq(input logic [127:0] k);
    @(posedge clk); #1;
    start = 1'b1;
    key_in = k;
    @(posedge clk); #1;
    start = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_idx(input logic [3:0] n, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (key_valid && round_idx == n) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 256; c++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; key_ready = 1'b0; key_in = '0;
    #2;
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got %b required 0", key_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b required 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got %b required 0", done); end
    total++; if (round_key !== 128'h0) begin bad++; $display("FAIL rst_key got %h required 0", round_key); end
    total++; if (round_idx !== 4'd0) begin bad++; $display("FAIL rst_idx got %0d required 0", round_idx); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Free-running sequence: 11 back-to-back keys, then one done pulse
  task automatic test_vector(input logic [127:0] k10, input logic [127:0] k1, input logic [127:0] k0);
    int vcnt;
    int after;
    vcnt = 0;
    after = 0;
    key_ready = 1'b1;
    push_all();
    start_seq(k10);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (key_valid) begin
        vcnt++;
        if (round_idx == 4'd10) begin
          total++; if (round_key !== k10) begin bad++; $display("FAIL vec_idx10 got %h required %h", round_key, k10); end
        end
        if (round_idx == 4'd1) begin
          total++; if (round_key !== k1) begin bad++; $display("FAIL vec_idx1 got %h required %h", round_key, k1); end
        end
        if (round_idx == 4'd0) begin
          total++; if (round_key !== k0) begin bad++; $display("FAIL vec_idx0 got %h required %h", round_key, k0); end
        end
      end else begin
        after++;
        total++;
        if (after == 1) begin
          if ({done, busy} !== 2'b10) begin bad++; $display("FAIL vec_done got done=%b busy=%b required done=1 busy=0", done, busy); end
        end else if (done !== 1'b0) begin
          bad++; $display("FAIL vec_done_width got done=%b required 0", done);
        end
      end
    end
    total++; if (vcnt != 11) begin bad++; $display("FAIL vec_count got %0d required 11", vcnt); end
    total++; if (sb_q.size() != 0) begin bad++; $display("FAIL vec_left got %0d required 0", sb_q.size()); end
  endtask

  // Random consumer stalls: held values stay put, exactly 11 transfers
  task automatic test_backpressure();
    int x0;
    bit hold, fin;
    logic [3:0] h_idx;
    logic [127:0] h_key;
    hold = 1'b0; fin = 1'b0; h_idx = '0; h_key = '0;
    expand(K0_FIPS);
    push_all();
    key_ready = 1'b0;
    x0 = xfers;
    start_seq(K10_FIPS);
    for (int c = 0; c < 400 && !fin; c++) begin
      @(negedge clk);
      if (hold) begin
        total++;
        if (!key_valid || round_idx !== h_idx || round_key !== h_key) begin
          bad++;
          $display("FAIL bp_hold got v=%b idx=%0d key=%h required v=1 idx=%0d key=%h",
                   key_valid, round_idx, round_key, h_idx, h_key);
        end
      end
      hold = key_valid && !key_ready;
      h_idx = round_idx;
      h_key = round_key;
      if (done) fin = 1'b1;
      @(posedge clk); #1;
      key_ready = 1'($urandom_range(0, 1));
    end
    key_ready = 1'b1;
    total++; if (!fin) begin bad++; $display("FAIL bp_timeout got done=0 required done=1"); end
    total++; if (xfers - x0 != 11) begin bad++; $display("FAIL bp_count got %0d required 11", xfers - x0); end
    total++; if (sb_q.size() != 0) begin bad++; $display("FAIL bp_left got %0d required 0", sb_q.size()); end
  endtask

  // start while busy, with a different key, must not disturb the sequence
  task automatic test_start_ignored();
    bit ok;
    expand(K0_FIPS);
    push_all();
    key_ready = 1'b1;
    start_seq(K10_FIPS);
    wait_idx(4'd7, ok);
    total++; if (!ok) begin bad++; $display("FAIL ign_reach got none required idx 7"); end
    @(posedge clk); #1;
    start = 1'b1;
    key_in = K10_TEAM;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    total++; if ({key_valid, round_idx} !== {1'b1, 4'd5}) begin bad++; $display("FAIL ign_idx got v=%b idx=%0d required v=1 idx=5", key_valid, round_idx); end
    wait_done(ok);
    total++; if (!ok) begin bad++; $display("FAIL ign_done got 0 required 1"); end
    repeat (2) @(negedge clk);
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL ign_restart got %b required 0", key_valid); end
    total++; if (sb_q.size() != 0) begin bad++; $display("FAIL ign_left got %0d required 0", sb_q.size()); end
  endtask

  // Reset in the middle aborts at once; a fresh start runs a full sequence
  task automatic test_reset_mid();
    bit ok;
    expand(K0_FIPS);
    push_all();
    key_ready = 1'b1;
    start_seq(K10_FIPS);
    wait_idx(4'd5, ok);
    total++; if (!ok) begin bad++; $display("FAIL rm_reach got none required idx 5"); end
    @(posedge clk); #1;
    total++; if (round_idx !== 4'd4) begin bad++; $display("FAIL rm_at4 got %0d required 4", round_idx); end
    reset = 1'b1;
    #1;
    total++; if ({key_valid, busy, done} !== 3'b000) begin bad++; $display("FAIL rm_abort got v=%b b=%b d=%b required 000", key_valid, busy, done); end
    sb_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++; if ({key_valid, done} !== 2'b00) begin bad++; $display("FAIL rm_nodone got v=%b d=%b required 00", key_valid, done); end
    push_all();
    start_seq(K10_FIPS);
    @(negedge clk);
    total++; if ({round_idx, round_key} !== {4'd10, K10_FIPS}) begin bad++; $display("FAIL rm_first got idx=%0d key=%h required idx=10 key=%h", round_idx, round_key, K10_FIPS); end
    wait_done(ok);
    total++; if (!ok || sb_q.size() != 0) begin bad++; $display("FAIL rm_full got done=%b left=%0d required done=1 left=0", ok, sb_q.size()); end
  endtask

  // start in the done cycle is accepted immediately
  task automatic test_start_in_done();
    bit ok;
    expand(K0_FIPS);
    push_all();
    key_ready = 1'b1;
    start_seq(K10_FIPS);
    wait_idx(4'd0, ok);
    total++; if (!ok) begin bad++; $display("FAIL sid_reach got none required idx 0"); end
    @(posedge clk); #1;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL sid_pulse got %b required 1", done); end
    push_all();
    start = 1'b1;
    key_in = K10_FIPS;
    @(posedge clk); #1;
    start = 1'b0;
    total++; if ({key_valid, round_idx, round_key} !== {1'b1, 4'd10, K10_FIPS}) begin
      bad++; $display("FAIL sid_first got v=%b idx=%0d key=%h required v=1 idx=10 key=%h", key_valid, round_idx, round_key, K10_FIPS);
    end
    wait_done(ok);
    total++; if (!ok || sb_q.size() != 0) begin bad++; $display("FAIL sid_full got done=%b left=%0d required done=1 left=0", ok, sb_q.size()); end
  endtask

  initial begin
    test_reset();
    expand(K0_FIPS);
    test_vector(K10_FIPS, K1_FIPS, K0_FIPS);
    expand(K0_TEAM);
    test_vector(K10_TEAM, K1_TEAM, K0_TEAM);
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    test_start_in_done();
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
